// File: rtl/df_pkg.sv
// Shared definitions for the divider slice: default widths, FSM state
// type and the coefficient-to-divisor decode.
package df_pkg;

   localparam int DF_DATA_W = 8;
   localparam int DF_FRAC_W = 7;
   localparam int DF_DW     = DF_DATA_W + DF_FRAC_W + 1;

   // The divisor never exceeds 47, so the remainder always fits in
   // 6 bits. The extra remainder bit holds the shifted-in trial value.
   localparam int REM_W = 7;
   localparam int DIV_W = 6;
   localparam int CNT_W = 5;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } df_state_t;

   // Same weighting as the coefficient multiplier: C = 5 + 2*c0 + 8*c1 + 32*c2
   function automatic logic [DIV_W-1:0] df_coef_to_div(input logic [2:0] coef);
      logic [DIV_W-1:0] c;
      c = 6'd5;
      if (coef[0]) c = c + 6'd2;
      if (coef[1]) c = c + 6'd8;
      if (coef[2]) c = c + 6'd32;
      return c;
   endfunction

endpackage

// File: rtl/df_div_step.sv
// One restoring-division step: shift the next dividend bit into the
// remainder and subtract the divisor when it fits.
module df_div_step
   import df_pkg::*;
(
   input  logic [REM_W-1:0] rem_in,
   input  logic             msb_in,
   input  logic [DIV_W-1:0] divisor,
   output logic [REM_W-1:0] rem_out,
   output logic             q_bit
);

   logic [REM_W:0] trial;

   // Compare the widened trial remainder against the divisor and restore
   // (keep the trial value) when the subtraction would go negative.
   always_comb begin
      trial   = {rem_in, msb_in};
      q_bit   = (trial >= {2'b00, divisor});
      rem_out = REM_W'(trial - (q_bit ? {2'b00, divisor} : '0));
   end

endmodule

// File: rtl/df_divider_c2.sv
// Sequential restoring divider: out = floor((data << FRAC_W) / C), one
// quotient bit per clock, valid/ready on both sides, saturating output.
// Optional build macro DF_DIV_ROUND_EN: round half up by adding C>>1 to
// the dividend at load time; latency is unchanged.
module df_divider_c2
   import df_pkg::*;
#(
   parameter int DATA_W = DF_DATA_W,
   parameter int FRAC_W = DF_FRAC_W
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        coef,
   input  logic [DATA_W-1:0] data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out,
   output logic              sat
);

   localparam int DW = DATA_W + FRAC_W + 1;

   df_state_t        state;
   df_state_t        state_nxt;
   logic [DW-1:0]    dividend;
   logic [REM_W-1:0] rem;
   logic [DIV_W-1:0] divisor;
   logic [CNT_W-1:0] count;

   logic [DIV_W-1:0] c_in;
   logic [DW-1:0]    load_val;
   logic [REM_W-1:0] rem_nxt;
   logic             q_bit;
   logic [DW-1:0]    quot_final;
   logic             quot_sat;

   // The dividend register doubles as the quotient register: each step
   // shifts the top dividend bit out and the new quotient bit in, so
   // after DW steps it holds the full quotient.
   df_div_step u_step (
      .rem_in  (rem),
      .msb_in  (dividend[DW-1]),
      .divisor (divisor),
      .rem_out (rem_nxt),
      .q_bit   (q_bit)
   );

   assign c_in       = df_coef_to_div(coef);
   assign quot_final = {dividend[DW-2:0], q_bit};
   assign quot_sat   = |quot_final[DW-1:DATA_W];
   assign in_ready   = (state == IDLE);
   assign out_valid  = (state == DONE);

`ifdef DF_DIV_ROUND_EN
   assign load_val = {1'b0, data, {FRAC_W{1'b0}}} + {{(DW-DIV_W){1'b0}}, (c_in >> 1)};
`else
   assign load_val = {1'b0, data, {FRAC_W{1'b0}}};
`endif

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state: accept in IDLE, run DW steps, hold DONE until taken.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)              state_nxt = CALC;
         CALC:    if (count == '0)           state_nxt = DONE;
         DONE:    if (out_ready)             state_nxt = IDLE;
         default:                            state_nxt = IDLE;
      endcase
   end

   // Datapath: load operands, iterate, and register the saturated result
   // on the final step so out/sat are stable throughout DONE and beyond.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dividend <= '0;
         rem      <= '0;
         divisor  <= '0;
         count    <= '0;
         out      <= '0;
         sat      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  dividend <= load_val;
                  divisor  <= c_in;
                  rem      <= '0;
                  count    <= CNT_W'(DW - 1);
               end
            end
            CALC: begin
               dividend <= quot_final;
               rem      <= rem_nxt;
               count    <= count - CNT_W'(1);
               if (count == '0) begin
                  out <= quot_sat ? '1 : quot_final[DATA_W-1:0];
                  sat <= quot_sat;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_df_divider_c2.sv
// Bench for df_divider_c2: directed cases, backpressure, mid-operation
// reset, randomized operands and a back-to-back stream, all checked
// against an arithmetic reference of floor((d<<7)/C) with saturation.
module tb_df_divider_c2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] coef;
   logic [7:0] data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out;
   logic       sat;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef DF_DIV_ROUND_EN
   localparam logic [7:0] EXP_ONE   = 8'd26;
   localparam logic [7:0] EXP_THIRTY = 8'd104;
`else
   localparam logic [7:0] EXP_ONE   = 8'd25;
   localparam logic [7:0] EXP_THIRTY = 8'd103;
`endif

   always #5 clk = ~clk;

   df_divider_c2 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .coef      (coef),
      .data      (data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .sat       (sat)
   );

   // Reference result {sat, out} from plain arithmetic
   function automatic logic [8:0] ref_div(input logic [7:0] d, input logic [2:0] c);
      int unsigned cv;
      int unsigned num;
      int unsigned q;
      cv = 5;
      if (c[0]) cv += 2;
      if (c[1]) cv += 8;
      if (c[2]) cv += 32;
      num = 32'(d) << 7;
`ifdef DF_DIV_ROUND_EN
      num += cv / 2;
`endif
      q = num / cv;
      if (q > 255) return {1'b1, 8'hFF};
      return {1'b0, q[7:0]};
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Present an operand in IDLE and let it be accepted on the next edge;
   // coef/data are scrambled afterwards to show the divisor is latched.
   task automatic apply_stimulus(input logic [7:0] d, input logic [2:0] c);
      in_valid = 1'b1;
      data     = d;
      coef     = c;
      check_output("in_ready_before_accept", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      data     = 8'($urandom);
      coef     = 3'($urandom);
   endtask

   // Called just after the accepting edge (cycle 1 of the operation);
   // the handshake cycle is cycle 0 and out_valid is due in cycle 17.
   task automatic wait_result(input string tag, input logic [7:0] exp_out, input logic exp_sat);
      int cyc;
      cyc = 1;
      while (!out_valid && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      check_output({tag, "_latency"}, 32'(cyc), 32'd17);
      check_output({tag, "_out"}, 32'(out), 32'(exp_out));
      check_output({tag, "_sat"}, 32'(sat), 32'(exp_sat));
      check_output({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
   endtask

   task automatic release_result(input string tag, input logic [7:0] exp_out);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_output({tag, "_valid_cleared"}, 32'(out_valid), 32'd0);
      check_output({tag, "_back_idle"}, 32'(in_ready), 32'd1);
      check_output({tag, "_out_kept"}, 32'(out), 32'(exp_out));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [8:0] e;
      logic [8:0] e2;
      logic [7:0] d;
      logic [2:0] c;
      logic [7:0] bb_d [4];
      logic [2:0] bb_c [4];
      logic [8:0] exp_q [$];
      int idx, got, last, cyc;
      logic overlap;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      coef      = 3'd0;
      data      = 8'd0;

      // Reset state
      #12;
      check_output("reset_in_ready", 32'(in_ready), 32'd1);
      check_output("reset_out_valid", 32'(out_valid), 32'd0);
      check_output("reset_out", 32'(out), 32'd0);
      check_output("reset_sat", 32'(sat), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed cases
      apply_stimulus(8'd1, 3'b000);
      wait_result("c5_d1", EXP_ONE, 1'b0);
      release_result("c5_d1", EXP_ONE);

      apply_stimulus(8'd30, 3'b100);
      wait_result("c37_d30", EXP_THIRTY, 1'b0);
      release_result("c37_d30", EXP_THIRTY);

      apply_stimulus(8'd47, 3'b111);
      wait_result("c47_exact", 8'd128, 1'b0);
      release_result("c47_exact", 8'd128);

      apply_stimulus(8'd255, 3'b000);
      wait_result("c5_sat", 8'hFF, 1'b1);
      release_result("c5_sat", 8'hFF);

      // Backpressure: hold the result, offer a second operand meanwhile
      e  = ref_div(8'd200, 3'b010);
      e2 = ref_div(8'd77, 3'b101);
      apply_stimulus(8'd200, 3'b010);
      wait_result("bp_first", e[7:0], e[8]);
      in_valid = 1'b1;
      data     = 8'd77;
      coef     = 3'b101;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         check_output("bp_hold_valid", 32'(out_valid), 32'd1);
         check_output("bp_hold_out", 32'(out), 32'(e[7:0]));
         check_output("bp_hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_output("bp_release_valid", 32'(out_valid), 32'd0);
      check_output("bp_release_idle", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_output("bp_second_accepted", 32'(in_ready), 32'd0);
      wait_result("bp_second", e2[7:0], e2[8]);
      release_result("bp_second", e2[7:0]);

      // Reset in the middle of CALC
      apply_stimulus(8'd90, 3'b001);
      repeat (7) begin
         @(posedge clk); #1;
      end
      #2 rst_n = 1'b0;
      #1;
      check_output("midrst_in_ready", 32'(in_ready), 32'd1);
      check_output("midrst_out_valid", 32'(out_valid), 32'd0);
      check_output("midrst_out", 32'(out), 32'd0);
      check_output("midrst_sat", 32'(sat), 32'd0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;
      apply_stimulus(8'd10, 3'b011);
      wait_result("after_rst", 8'd85, 1'b0);
      release_result("after_rst", 8'd85);

      // Randomized operands against the reference
      for (int i = 0; i < 6; i++) begin
         d = 8'($urandom);
         c = 3'($urandom);
         e = ref_div(d, c);
         apply_stimulus(d, c);
         wait_result("rand", e[7:0], e[8]);
         release_result("rand", e[7:0]);
      end

      // Back-to-back stream with both handshakes held high
      for (int i = 0; i < 4; i++) begin
         bb_d[i] = 8'($urandom);
         bb_c[i] = 3'($urandom);
      end
      idx     = 0;
      got     = 0;
      last    = -1;
      cyc     = 0;
      overlap = 1'b0;
      out_ready = 1'b1;
      while (got < 4 && cyc < 200) begin
         if (idx < 4) begin
            in_valid = 1'b1;
            data     = bb_d[idx];
            coef     = bb_c[idx];
         end else begin
            in_valid = 1'b0;
         end
         if (in_ready && out_valid) overlap = 1'b1;
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_div(bb_d[idx], bb_c[idx]));
            idx++;
         end
         if (out_valid) begin
            if (exp_q.size() == 0) e = 9'h1FF;
            else                   e = exp_q.pop_front();
            check_output("b2b_out", 32'(out), 32'(e[7:0]));
            check_output("b2b_sat", 32'(sat), 32'(e[8]));
            if (last >= 0) check_output("b2b_spacing", 32'(cyc - last), 32'd18);
            last = cyc;
            got++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check_output("b2b_result_count", 32'(got), 32'd4);
      check_output("b2b_no_overlap", 32'(overlap), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
